matrix_buf: RTL
===============

// Module: matrix_buf
// PURPOSE
//   Parametrised ROW x COL matrix buffer. Loads N=ROW*COL elements in row-major order
//   through a valid/ready input stream, holds them, and streams them back out.
//   Readout is row-major or transposed (column-major) through a valid/ready output.
//   Sits between a matrix source (DMA or host) and downstream arithmetic.
// PARAMETERS
//   ROW    5   matrix rows, >=1
//   COL    4   matrix columns, >=1
//   WIDTH  16  element width in bits
//   (derived) N = ROW*COL; AW = $clog2(N), with a minimum of 1 -- index width
// PORTS
//   clk        in   1      single clock; all logic on posedge
//   rst_n      in   1      synchronous reset, active-low
//   wr         in   1      start-load pulse
//   valid      in   1      input element valid
//   data       in   WIDTH  input element
//   in_ready   out  1      buffer accepts an element this cycle
//   rd         in   1      start-readout pulse
//   trans      in   1      readout mode, sampled with rd: 0 = row-major, 1 = transposed
//   out_valid  out  1      out_data valid
//   out_ready  in   1      downstream accepts out_data
//   out_data   out  WIDTH  output element (registered)
//   out_last   out  1      high together with the final element of a readout
//   full       out  1      buffer holds a complete matrix
//   busy       out  1      state is LOAD or READ
// BEHAVIOUR
// - Reset (rst_n=0 at posedge):
//   - state=IDLE; in_ready, out_valid, out_last, full and busy all 0; out_data=0.
//   - Memory contents are not cleared.
//   - A reset during LOAD or READ aborts the operation immediately.
// - Storage: element (r,c) is stored at mem[r*COL+c]. Accepted input element k goes to mem[k].
// - FSM states: IDLE, LOAD, HOLD, READ.
//   - IDLE: wr=1 -> LOAD, write index cleared to 0. rd is ignored because the buffer is empty.
//   - LOAD: in_ready=1. An element is accepted on valid && in_ready.
//     - Accepting element N-1 -> HOLD; full=1 from the next cycle.
//     - wr and rd are ignored during LOAD.
//     - in_ready drops in the cycle after the last accept.
//   - HOLD: full=1, in_ready=0.
//     - rd=1 -> READ, and trans is latched.
//     - wr=1 (with rd=0) -> LOAD; full=0 the next cycle; old data is overwritten progressively.
//     - If rd and wr are both 1, rd wins and wr is dropped.
//   - READ: busy=1.
//     - 1-cycle latency: the cycle after rd, out_valid=1 and out_data holds element 0 of the sequence.
//     - Row-major sequence: mem[0], mem[1], ..., mem[N-1].
//     - Transposed sequence: for c = 0..COL-1, for r = 0..ROW-1, emit mem[r*COL+c].
//     - Handshake occurs on out_valid && out_ready. The next element is presented the following cycle, so an element can transfer every cycle.
//     - While out_valid && !out_ready, out_data and out_last are held stable.
//     - out_last=1 only while the final element is presented.
//     - Final handshake -> HOLD; out_valid=0 and out_last=0 from the next cycle.
//     - full stays 1, so the matrix can be read again in either mode.
//     - wr and rd are ignored during READ.
// - Index arithmetic:
//   - Row/column counters are AW bits wide, or of the matching clog2 width.
//   - Counters wrap to 0 on completion.
//   - No multiply in the datapath: transposed addressing adds COL per step, and on a column wrap resets to c+1.
// - ROW=1 or COL=1: transposed order equals row-major order.
// - N=1: a single accept fills the buffer; the single output has out_last=1.
// - valid is ignored outside LOAD; out_ready is ignored when out_valid=0.
// TESTING
//   T1 (ROW=2, COL=3): wr, then data 1..6 with valid held high; rd with trans=0, out_ready=1
//      -> out 1,2,3,4,5,6 on consecutive cycles; out_last with 6; full=1 throughout; back in HOLD.
//   T2: same load; rd with trans=1 -> out 1,4,2,5,3,6; out_last with 6.
//      Then a second rd with trans=0 -> out 1..6 again (contents retained).
//   T3: READ with out_ready toggling 1,0,0,1,... -> each element held stable while stalled;
//      no element lost or duplicated; total of 6 handshakes.
//   T4: LOAD with gaps in valid, plus wr and rd pulses mid-load -> pulses ignored;
//      full rises exactly 1 cycle after the 6th accept; in_ready=0 afterwards.
//   T5: rst_n=0 for 1 cycle after the 3rd output of a READ -> next cycle state=IDLE;
//      out_valid=0, full=0, busy=0; a following rd produces no output.
//   T6: in HOLD, rd=1 and wr=1 in the same cycle -> READ entered; in_ready stays 0.
//      Default 5x4 full load/readout in trans=1 -> 20 outputs in column-major order.

Source files
------------

// File: rtl/matrix_buf_if.sv
// Stream and control bundle for matrix_buf: valid/ready load path, valid/ready readout path
// and status flags.
interface matrix_buf_if #(
    parameter int WIDTH = 16
) ();
    logic             wr;
    logic             valid;
    logic [WIDTH-1:0] data;
    logic             in_ready;
    logic             rd;
    logic             trans;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_last;
    logic             full;
    logic             busy;

    modport master (
        output wr, valid, data, rd, trans, out_ready,
        input  in_ready, out_valid, out_data, out_last, full, busy
    );

    modport slave (
        input  wr, valid, data, rd, trans, out_ready,
        output in_ready, out_valid, out_data, out_last, full, busy
    );
endinterface

// File: rtl/matrix_buf.sv
// ROW x COL matrix buffer: row-major load over a valid/ready stream, then row-major or
// transposed readout with a registered valid/ready output.
module matrix_buf #(
    parameter int ROW   = 5,
    parameter int COL   = 4,
    parameter int WIDTH = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    matrix_buf_if.slave  bus
);
    localparam int N  = ROW * COL;
    localparam int AW = (N   > 1) ? $clog2(N)   : 1;
    localparam int RW = (ROW > 1) ? $clog2(ROW) : 1;
    localparam int CW = (COL > 1) ? $clog2(COL) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_HOLD = 2'd2,
        ST_READ = 2'd3
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] mem_r [N];
    logic [AW-1:0]    wr_idx_r;
    logic [AW-1:0]    addr_r;
    logic [AW-1:0]    cnt_r;
    logic [RW-1:0]    row_r;
    logic [CW-1:0]    col_r;
    logic             trans_r;
    logic             in_ready_r;
    logic             out_valid_r;
    logic             out_last_r;
    logic [WIDTH-1:0] out_data_r;
    logic             full_r;
    logic             busy_r;

    logic [AW-1:0]    nxt_addr_s;
    logic [AW-1:0]    nxt_cnt_s;
    logic [RW-1:0]    nxt_row_s;
    logic [CW-1:0]    nxt_col_s;

    // Next readout address: +1 row-major; transposed steps by COL and restarts at column c+1.
    always_comb begin
        nxt_addr_s = addr_r;
        nxt_row_s  = row_r;
        nxt_col_s  = col_r;
        nxt_cnt_s  = cnt_r + AW'(1);
        if (trans_r) begin
            if (row_r == RW'(ROW - 1)) begin
                nxt_row_s  = {RW{1'b0}};
                nxt_col_s  = col_r + CW'(1);
                nxt_addr_s = AW'(col_r) + AW'(1);
            end else begin
                nxt_row_s  = row_r + RW'(1);
                nxt_addr_s = addr_r + AW'(COL);
            end
        end else begin
            nxt_addr_s = addr_r + AW'(1);
        end
    end

    // Element storage; deliberately not reset so contents survive rst_n.
    always_ff @(posedge clk) begin
        if (rst_n && (state_r == ST_LOAD) && bus.valid) begin
            mem_r[wr_idx_r] <= bus.data;
        end
    end

    // Control FSM with registered handshake and status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            wr_idx_r    <= {AW{1'b0}};
            addr_r      <= {AW{1'b0}};
            cnt_r       <= {AW{1'b0}};
            row_r       <= {RW{1'b0}};
            col_r       <= {CW{1'b0}};
            trans_r     <= 1'b0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            out_data_r  <= {WIDTH{1'b0}};
            full_r      <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.wr) begin
                        state_r    <= ST_LOAD;
                        wr_idx_r   <= {AW{1'b0}};
                        in_ready_r <= 1'b1;
                        busy_r     <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (bus.valid) begin
                        if (wr_idx_r == AW'(N - 1)) begin
                            state_r    <= ST_HOLD;
                            wr_idx_r   <= {AW{1'b0}};
                            in_ready_r <= 1'b0;
                            full_r     <= 1'b1;
                            busy_r     <= 1'b0;
                        end else begin
                            wr_idx_r <= wr_idx_r + AW'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    // rd takes priority over a simultaneous wr
                    if (bus.rd) begin
                        state_r     <= ST_READ;
                        trans_r     <= bus.trans;
                        addr_r      <= {AW{1'b0}};
                        cnt_r       <= {AW{1'b0}};
                        row_r       <= {RW{1'b0}};
                        col_r       <= {CW{1'b0}};
                        out_valid_r <= 1'b1;
                        out_last_r  <= (N == 1);
                        out_data_r  <= mem_r[0];
                        busy_r      <= 1'b1;
                    end else if (bus.wr) begin
                        state_r    <= ST_LOAD;
                        wr_idx_r   <= {AW{1'b0}};
                        in_ready_r <= 1'b1;
                        full_r     <= 1'b0;
                        busy_r     <= 1'b1;
                    end
                end
                ST_READ: begin
                    if (bus.out_ready) begin
                        if (out_last_r) begin
                            state_r     <= ST_HOLD;
                            out_valid_r <= 1'b0;
                            out_last_r  <= 1'b0;
                            busy_r      <= 1'b0;
                            addr_r      <= {AW{1'b0}};
                            cnt_r       <= {AW{1'b0}};
                            row_r       <= {RW{1'b0}};
                            col_r       <= {CW{1'b0}};
                        end else begin
                            addr_r     <= nxt_addr_s;
                            cnt_r      <= nxt_cnt_s;
                            row_r      <= nxt_row_s;
                            col_r      <= nxt_col_s;
                            out_data_r <= mem_r[nxt_addr_s];
                            out_last_r <= (nxt_cnt_s == AW'(N - 1));
                        end
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    in_ready_r  <= 1'b0;
                    out_valid_r <= 1'b0;
                    out_last_r  <= 1'b0;
                    full_r      <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_last  = out_last_r;
    assign bus.out_data  = out_data_r;
    assign bus.full      = full_r;
    assign bus.busy      = busy_r;

endmodule
